// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage sitting directly in front of a
// combinational-read instruction memory. Holds the PC, presents it as the
// memory address and registers the returned word toward decode with a
// valid/ready handshake. Supports stall, redirect, PC wrap at memory size
// and halting on a sentinel instruction word.
// Optional build macro: FETCH_ALIGN_CHECK_EN (misaligned redirects halt
// fetch and raise a sticky misalign_err instead of being rounded down).
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_WORDS = 16,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        misalign_err
);

    localparam int          AW        = $clog2(MEM_WORDS * 4);
    localparam logic [31:0] ADDR_MASK = (32'd1 << AW) - 32'd1;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_inc;
    logic [31:0] redirect_target;
    logic        redirect_bad;
    logic        load;

    // Sequential PC stepping wraps at the memory size; redirect targets are
    // masked into the same address window and forced onto a word boundary.
    assign pc_inc          = (pc_q + 32'd4) & ADDR_MASK;
    assign redirect_target = redirect_pc & ADDR_MASK & ~32'd3;

    // A new word is captured only while running, when no redirect is
    // flushing the stage and the output register is empty or draining.
    assign load = (state_q == RUN) && !redirect_valid && (!valid_q || out_ready);

`ifdef FETCH_ALIGN_CHECK_EN
    logic err_q;

    assign redirect_bad = (redirect_pc[1:0] != 2'b00);
    assign misalign_err = err_q;

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (redirect_valid && redirect_bad) begin
            err_q <= 1'b1;
        end
    end
`else
    assign redirect_bad = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Next-state and datapath decisions; redirect outranks any fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        if (redirect_valid) begin
            valid_d = 1'b0;
            if (redirect_bad) begin
                state_d = HALT;
            end else begin
                pc_d    = redirect_target;
                state_d = RUN;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (load) begin
                        instr_d = imem_data;
                        opc_d   = pc_q;
                        valid_d = 1'b1;
                        if (imem_data == HALT_WORD) begin
                            state_d = HALT;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
                HALT: begin
                    if (valid_q && out_ready) begin
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC & ADDR_MASK;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            opc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = opc_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by randomized traffic, all
// checked cycle by cycle against a behavioural model of the fetch stage.
module tb_fetch_unit;

    localparam int          MW       = 16;
    localparam int          SPAN     = MW * 4;
    localparam logic [31:0] HALT_W   = 32'hFFFF_FFFF;
    localparam logic [31:0] RST_PC   = 32'd0;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        misalign_err;

    logic [31:0] mem [0:MW-1];

    int compared = 0;
    int mismatched = 0;

    // Model state: mode 0 = boot, 1 = run, 2 = halt
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_opc;
    logic        m_err;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .MEM_WORDS(MW),
        .HALT_WORD(HALT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted),
        .misalign_err  (misalign_err)
    );

    assign imem_data = mem[imem_addr[$clog2(SPAN)-1:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, actual, expected);
        end
    endtask

    // Advance the model by one clock using the behavioural fetch rules.
    task automatic modelStep(input bit rs, input bit rv, input logic [31:0] rpc, input bit rdy);
        logic [31:0] word;
        bit          misaligned;
`ifdef FETCH_ALIGN_CHECK_EN
        misaligned = (rpc % 4) != 0;
`else
        misaligned = 1'b0;
`endif
        if (rs) begin
            m_mode  = 0;
            m_pc    = RST_PC % SPAN;
            m_valid = 1'b0;
            m_instr = 32'd0;
            m_opc   = 32'd0;
            m_err   = 1'b0;
        end else if (rv) begin
            m_valid = 1'b0;
            if (misaligned) begin
                m_err  = 1'b1;
                m_mode = 2;
            end else begin
                m_pc   = ((rpc % SPAN) / 4) * 4;
                m_mode = 1;
            end
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (!m_valid || rdy) begin
                word    = mem[(m_pc / 4) % MW];
                m_instr = word;
                m_opc   = m_pc;
                m_valid = 1'b1;
                if (word == HALT_W) m_mode = 2;
                else m_pc = (m_pc + 4) % SPAN;
            end
        end else begin
            if (m_valid && rdy) m_valid = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, step the model, then compare after the edge.
    task automatic applyStimulus(input bit rs, input bit rv, input logic [31:0] rpc, input bit rdy);
        rst            = rs;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        modelStep(rs, rv, rpc, rdy);
        @(posedge clk);
        #1;
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        checkOutput("out_instr", out_instr, m_instr);
        checkOutput("out_pc", out_pc, m_opc);
        checkOutput("imem_addr", imem_addr, m_pc);
        checkOutput("halted", {31'd0, halted}, {31'd0, m_mode == 2});
        checkOutput("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, rdy);
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        out_ready = 1'b1;
        for (int i = 0; i < MW; i++) mem[i] = 32'd1000 + i;
        mem[0]  = 32'd10;
        mem[1]  = 32'd20;
        mem[2]  = 32'd99;
        mem[3]  = 32'd123;
        mem[15] = 32'd7;
        #2;

        // Boot and stream 10/20/99/123
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        run(6, 1'b1);

        // Stall while 20 is presented, then release
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        run(3, 1'b1);
        run(3, 1'b0);
        run(4, 1'b1);

        // Redirect to 12 while 20 is valid, then a masked redirect
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        run(3, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'd12, 1'b1);
        run(2, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0104, 1'b1);
        run(2, 1'b1);

        // Wrap from the last word back to address 0
        applyStimulus(1'b0, 1'b1, 32'd60, 1'b1);
        run(3, 1'b1);

        // Halt sentinel, then resume via redirect
        mem[2] = HALT_W;
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        run(6, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'd0, 1'b1);
        run(4, 1'b1);
        mem[2] = 32'd99;

        // Reset during a stall, then a misaligned redirect
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        run(3, 1'b1);
        run(2, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        run(1, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'd6, 1'b1);
        run(3, 1'b1);

        // Randomized traffic
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            bit          rs;
            bit          rv;
            bit          rdy;
            logic [31:0] rpc;
            if ($urandom_range(0, 3) == 0) begin
                mem[$urandom_range(0, MW - 1)] = ($urandom_range(0, 5) == 0) ? HALT_W : $urandom;
            end
            rs  = ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, SPAN - 1)) : $urandom;
            applyStimulus(rs, rv, rpc, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction memory. Holds the program counter and drives the word address into the combinational-read memory. Captures the returned instruction into an output register with a valid/ready handshake toward decode. Supports stall, redirect (branch/jump flush), PC wrap-around at memory size, and halt on a sentinel instruction.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset; must be word aligned.
MEM_WORDS, 16, instruction memory depth in 32-bit words; power of two.
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
imem_addr  output  32  byte address to memory; equals internal pc
imem_data  input  32  instruction word; valid the same cycle as imem_addr
redirect_valid  input  1  load redirect_pc and flush output
redirect_pc  input  32  redirect target byte address
out_valid  output  1  out_instr/out_pc hold a valid instruction
out_ready  input  1  decode accepts the instruction this cycle
out_instr  output  32  fetched instruction
out_pc  output  32  byte address of out_instr
halted  output  1  high while state is HALT
misalign_err  output  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset: synchronous, active-high on clk. Reset overrides every other input, including mid-stall and mid-redirect. On reset: pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, state=BOOT, halted=0, misalign_err=0.
- imem_addr = pc, combinational from the register. The memory indexes by addr>>2, so pc advances in steps of 4.
- Address mask: AW = log2(MEM_WORDS*4).
  - pc bits [31:AW] are always 0.
  - pc+4 wraps modulo MEM_WORDS*4. For the default, 60 -> 0.
  - redirect_pc is masked the same way before it is loaded.
- A transfer occurs when out_valid && out_ready.
- A load occurs when state==RUN && !redirect_valid && (!out_valid || out_ready).
- States:
  - BOOT: out_valid=0, no fetch. Moves to RUN on the next cycle unconditionally. A redirect in BOOT still loads pc.
  - RUN, on load:
    - out_instr<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+4 (wrapped).
    - If imem_data==HALT_WORD: the word is still delivered, pc does not advance, and next state is HALT.
  - RUN, no load (stall: out_valid=1, out_ready=0): pc, out_instr, out_pc and out_valid hold, with no change for any number of cycles.
  - HALT: no fetch; pc holds; halted=1. out_valid clears after the pending word transfers. redirect_valid moves the state to RUN.
- Redirect (any state after reset):
  - Has priority over load. pc<=masked redirect_pc, out_valid<=0, no fetch that cycle.
  - The first instruction from the target appears with out_valid=1 one cycle later.
  - Redirect coincident with a transfer: the transfer counts as complete and the instruction is consumed. It is not re-presented.
- Latency: 1 cycle from pc to out_valid. Throughput: 1 instruction/cycle while out_ready=1.
- out_instr/out_pc are stable whenever out_valid=1 && out_ready=0.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err=1 (sticky until rst).
  - pc is left unchanged, out_valid<=0, and state goes to HALT.
- Not defined:
  - misalign_err is tied 0.
  - redirect_pc[1:0] are forced to 00 (target rounded down) and handled as a normal redirect.

Test Plan:
1. Memory words 0..3 = 10,20,99,123; reset, out_ready=1 -> BOOT 1 cycle, then out_instr 10/20/99/123 with out_pc 0/4/8/12 on consecutive cycles, out_valid=1 throughout.
2. Stall: out_ready=0 for 3 cycles while out_instr=20, out_pc=4 -> outputs and imem_addr=8 hold. Release -> 99 follows with no loss or duplicate.
3. Redirect to 32'd12 while out_instr=20 is valid -> next cycle out_valid=0, following cycle out_instr=123, out_pc=12. Redirect to 32'h0000_0104 -> pc=4 (masked).
4. Wrap: redirect to 60, memory[15]=7 -> out_instr 7 at out_pc 60, then out_pc 0 with out_instr 10.
5. memory[2]=HALT_WORD -> 10, 20, HALT_WORD delivered, then halted=1, out_valid=0, imem_addr stays 8. Redirect to 0 -> halted=0, fetch resumes at 0.
6. rst asserted mid-stream during a stall -> next edge out_valid=0, pc=RESET_PC. With FETCH_ALIGN_CHECK_EN, redirect to 6 -> misalign_err=1, halted=1. Without the macro -> fetch at 4.
